spatial_filter_frame_sequencer: RTL and testbench

Frame-level sequencer placed in front of `line_buffers_control` in the spatial filter IP. It accepts a valid/ready pixel stream and gates pixels into the line buffer datapath so that no line buffer holding unread rows is overwritten. It counts output window lines from the datapath's line-done pulse, flushes the line buffers at end of frame, and reports frame completion and framing errors to the SoC.

---
 rtl/spatial_filter_pkg.sv | 9 +
 rtl/spatial_filter_frame_sequencer_if.sv | 12 +
 rtl/line_occupancy_counter.sv | 36 +++
 rtl/spatial_filter_frame_sequencer.sv | 122 ++++++++++++
 tb/tb_spatial_filter_frame_sequencer.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/spatial_filter_pkg.sv
// Shared types and constants for the spatial filter frame sequencer.
package spatial_filter_pkg;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, FLUSH} seq_state_t;

  localparam int unsigned LB_WINDOW_LINES = 3;
  localparam int unsigned LB_COUNT        = 4;

endpackage

// File: rtl/spatial_filter_frame_sequencer_if.sv
// Valid/ready pixel stream with start-of-frame marker.
interface spatial_filter_frame_sequencer_if;

  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tuser;
  logic       s_tready;

  modport master (output s_tdata, output s_tvalid, output s_tuser, input s_tready);
  modport slave  (input s_tdata, input s_tvalid, input s_tuser, output s_tready);

endinterface

// File: rtl/line_occupancy_counter.sv
// Count of complete-but-unread lines held in the downstream line buffers.
module line_occupancy_counter
  import spatial_filter_pkg::*;
#(
  parameter int unsigned Capacity = LB_COUNT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  input  logic dec,
  output logic full
);

  logic [2:0] count_d, count_q;

  // A simultaneous write-completion and read-out cancel; reads of an empty set are dropped.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && !dec) begin
      if (count_q != 3'(Capacity)) count_d = count_q + 3'd1;
    end else if (dec && !inc) begin
      if (count_q != '0) count_d = count_q - 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign full = (count_q == 3'(Capacity));

endmodule

// File: rtl/spatial_filter_frame_sequencer.sv
// Gates a pixel stream into the line buffers so unread rows are never overwritten,
// tracks window rows read out, flushes the buffers and flags framing errors.
module spatial_filter_frame_sequencer
  import spatial_filter_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH      = 512,
  parameter int unsigned IMAGE_HEIGHT     = 512,
  parameter int unsigned NUM_LINE_BUFFERS = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   i_start,
  spatial_filter_frame_sequencer_if.slave        s_axis,
  output logic [7:0]                             o_pixel_data,
  output logic                                   o_pixel_data_valid,
  input  logic                                   i_line_done,
  output logic                                   o_lb_reset_n,
  output logic                                   o_busy,
  output logic                                   o_frame_done,
  output logic                                   o_sof_error
);

  localparam int unsigned ColW = $clog2(IMAGE_WIDTH);
  localparam int unsigned RowW = $clog2(IMAGE_HEIGHT + 1);
  localparam logic [ColW-1:0] ColLast = ColW'(IMAGE_WIDTH - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMAGE_HEIGHT - 1);
  localparam logic [RowW-1:0] OutMax  = RowW'(IMAGE_HEIGHT);
  // Each window row consumes LB_WINDOW_LINES input lines, so fewer rows come out than go in.
  localparam logic [RowW-1:0] DrainTarget = RowW'(IMAGE_HEIGHT - (LB_WINDOW_LINES - 1));

  seq_state_t      state_d, state_q;
  logic [ColW-1:0] col_d, col_q;
  logic [RowW-1:0] row_d, row_q;
  logic [RowW-1:0] out_d, out_q;
  logic            sof_err_d, sof_err_q;
  logic            full, ready, accept, line_complete, start_frame;

  assign start_frame   = (state_q == IDLE) && i_start;
  assign accept        = s_axis.s_tvalid && ready;
  assign line_complete = accept && (col_q == ColLast);

  line_occupancy_counter #(
    .Capacity (NUM_LINE_BUFFERS)
  ) u_occupancy (
    .clk   (clk),
    .reset (reset),
    .clear (start_frame),
    .inc   (line_complete),
    .dec   (i_line_done),
    .full  (full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_start) state_d = FILL;
      FILL:    if (line_complete && (row_q == RowLast)) state_d = DRAIN;
      DRAIN:   if (out_d >= DrainTarget) state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready        = (state_q == FILL) && !full;
    o_busy       = (state_q != IDLE);
    o_frame_done = (state_q == FLUSH);
    o_lb_reset_n = !(reset || (state_q == FLUSH));
  end

  assign s_axis.s_tready    = ready;
  assign o_pixel_data       = s_axis.s_tdata;
  assign o_pixel_data_valid = accept;
  assign o_sof_error        = sof_err_q;

  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    out_d     = out_q;
    sof_err_d = sof_err_q;
    if (start_frame) begin
      col_d     = '0;
      row_d     = '0;
      out_d     = '0;
      sof_err_d = 1'b0;
    end else begin
      if (accept) begin
        // The marker must be present on pixel (0,0) and nowhere else.
        if (s_axis.s_tuser != ((row_q == '0) && (col_q == '0))) sof_err_d = 1'b1;
        if (line_complete) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      if (i_line_done && ((state_q == FILL) || (state_q == DRAIN)) && (out_q != OutMax)) begin
        out_d = out_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q     <= '0;
      row_q     <= '0;
      out_q     <= '0;
      sof_err_q <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      out_q     <= out_d;
      sof_err_q <= sof_err_d;
    end
  end

endmodule

// File: tb/tb_spatial_filter_frame_sequencer.sv
// Randomized frames against a frame-level reference model, with a pixel scoreboard.
module tb_spatial_filter_frame_sequencer;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int NLB  = 4;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_start = 1'b0;
  logic       i_line_done = 1'b0;
  logic [7:0] o_pixel_data;
  logic       o_pixel_data_valid, o_lb_reset_n, o_busy, o_frame_done, o_sof_error;

  spatial_filter_frame_sequencer_if s_axis ();

  spatial_filter_frame_sequencer #(
    .IMAGE_WIDTH      (W),
    .IMAGE_HEIGHT     (H),
    .NUM_LINE_BUFFERS (NLB)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .i_start            (i_start),
    .s_axis             (s_axis),
    .o_pixel_data       (o_pixel_data),
    .o_pixel_data_valid (o_pixel_data_valid),
    .i_line_done        (i_line_done),
    .o_lb_reset_n       (o_lb_reset_n),
    .o_busy             (o_busy),
    .o_frame_done       (o_frame_done),
    .o_sof_error        (o_sof_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_pix;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 filling, 2 draining, 3 flushing.
  int   m_phase = 0, m_pix = 0, m_stored = 0, m_out = 0;
  bit   m_err = 0;
  bit   m_ready, m_acc, m_lc;

  always @(negedge clk) begin
    if (reset) begin
      m_phase = 0; m_pix = 0; m_stored = 0; m_out = 0; m_err = 0;
      check("rst_ready", s_axis.s_tready, 0);
      check("rst_valid", o_pixel_data_valid, 0);
      check("rst_busy", o_busy, 0);
      check("rst_frame_done", o_frame_done, 0);
      check("rst_sof_error", o_sof_error, 0);
      check("rst_lb_reset_n", o_lb_reset_n, 0);
    end else begin
      m_ready = (m_phase == 1) && (m_stored < NLB);
      m_acc   = s_axis.s_tvalid && m_ready;
      check("ready", s_axis.s_tready, m_ready);
      check("pix_valid", o_pixel_data_valid, m_acc);
      check("busy", o_busy, m_phase != 0);
      check("frame_done", o_frame_done, m_phase == 3);
      check("lb_reset_n", o_lb_reset_n, m_phase != 3);
      check("sof_error", o_sof_error, m_err);
      if (m_phase == 0) begin
        if (i_start) begin
          m_phase = 1; m_pix = 0; m_stored = 0; m_out = 0; m_err = 0;
        end else if (i_line_done && m_stored > 0) begin
          m_stored--;
        end
      end else begin
        m_lc = 0;
        if (m_acc) begin
          if (s_axis.s_tuser != (m_pix == 0)) m_err = 1;
          m_lc = (m_pix % W) == W - 1;
          m_pix++;
        end
        if (m_lc && !i_line_done && m_stored < NLB) m_stored++;
        else if (i_line_done && !m_lc && m_stored > 0) m_stored--;
        if ((m_phase == 1 || m_phase == 2) && i_line_done && m_out < H) m_out++;
        case (m_phase)
          1: if (m_pix == NPIX) m_phase = 2;
          2: if (m_out >= H - 2) m_phase = 3;
          default: m_phase = 0;
        endcase
      end
    end
  end

  // Scoreboard monitor: every forwarded pixel must be the next one the driver offered.
  always @(negedge clk) begin
    if (!reset && o_pixel_data_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pixel", 1, 0);
      end else begin
        exp_pix = exp_q.pop_front();
        check("pixel_data", o_pixel_data, exp_pix);
      end
    end
  end

  // ld_mode 0: random line_done; 1: none until cycle 50, one pulse, none until 80;
  // 2: none until forced alongside the 32nd accepted pixel.
  task automatic run_frame(input int vpct, input int ldpct, input int ld_mode,
                           input int err_idx, input bit poke, input int reset_at);
    int p, cyc;
    bit done, acc, ld;
    p = 0; cyc = 0; done = 0;
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    while (!done && cyc < 3000) begin
      if (!s_axis.s_tvalid && p < NPIX && $urandom_range(99) < vpct) begin
        s_axis.s_tvalid = 1'b1;
        s_axis.s_tdata  = 8'($urandom);
        s_axis.s_tuser  = (p == 0) || (p == err_idx);
        exp_q.push_back(s_axis.s_tdata);
      end
      case (ld_mode)
        1: begin
          if (cyc == 50) check("accepted_before_release", p, 32);
          if (cyc == 80) check("accepted_after_release", p, 40);
          ld = (cyc == 50) || (cyc >= 80 && $urandom_range(99) < ldpct);
        end
        2: ld = (p == 31 && s_axis.s_tvalid && s_axis.s_tready) ||
                (p >= 32 && $urandom_range(99) < ldpct);
        default: ld = $urandom_range(99) < ldpct;
      endcase
      i_line_done = ld;
      i_start     = poke && ($urandom_range(7) == 0);
      @(negedge clk);
      acc = s_axis.s_tvalid && s_axis.s_tready;
      if (acc) p++;
      if (o_frame_done) done = 1;
      @(posedge clk); #1;
      if (acc) s_axis.s_tvalid = 1'b0;
      cyc++;
      if (reset_at >= 0 && p == reset_at) begin
        reset = 1'b1;
        s_axis.s_tvalid = 1'b0; i_line_done = 1'b0; i_start = 1'b0;
        @(negedge clk);
        exp_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        return;
      end
    end
    s_axis.s_tvalid = 1'b0; i_line_done = 1'b0; i_start = 1'b0;
    check("frame_done_seen", done, 1);
    check("pixels_accepted", p, NPIX);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    s_axis.s_tvalid = 1'b0;
    s_axis.s_tdata  = '0;
    s_axis.s_tuser  = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run_frame(100, 25, 0, -1, 0, -1);
    run_frame(100, 25, 1, -1, 0, -1);
    run_frame(100, 25, 2, -1, 0, -1);
    run_frame(70, 25, 0, 5, 0, -1);
    run_frame(70, 20, 0, -1, 0, -1);
    run_frame(100, 20, 0, -1, 0, 20);
    run_frame(100, 25, 0, -1, 0, -1);
    run_frame(80, 25, 0, -1, 1, -1);
    for (int i = 0; i < 4; i++) begin
      run_frame(40 + $urandom_range(60), 5 + $urandom_range(40), 0, -1, 1, -1);
    end
    repeat (4) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
